// File: rtl/uart_tx_buffered_pkg.sv
// Constants shared by the UART transmitter and receiver: the frame state
// encoding and the default bit period.
package uart_tx_buffered_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP_BIT  = 3'd3,
    ST_CLEANUP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. Full/empty are registered from
// the next occupancy, so they are valid on the same edge the count changes.
// Pushes while full are ignored even when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic                        i_push,
  input  logic [7:0]                  i_data,
  input  logic                        i_pop,
  output logic [7:0]                  o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, count and registered flags.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage write port.
  always_ff @(posedge i_Clk) begin
    // NOTE: the storage array is not reset; the pointers and count define which slots are valid, so stale data is never observed.
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first.
// A small FIFO absorbs producer bursts; the FSM pops one byte per frame.
// All outputs are registered and computed from the state being entered, so
// the line changes on the same edge as the state.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_serial;
  logic              r_active;
  logic              r_done;
  logic              w_serial_next;
  logic              w_active_next;
  logic              w_done_next;
  logic              w_bit_end;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [7:0]        w_fifo_data;
  logic [CNT_W-1:0]  w_fifo_count_unused;  // occupancy, kept for debug visibility

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_push  (i_TX_DV),
    .i_data  (i_TX_Byte),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count_unused)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Next-state, baud counter, shift register and registered-output values.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_data;
          w_bit_idx_next = '0;
          w_state_next   = ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = ST_DATA_BITS;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA_BITS: begin
        if (w_bit_end) begin
          w_baud_next    = '0;
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = ST_STOP_BIT;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP_BIT: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = ST_CLEANUP;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      ST_CLEANUP: begin
        w_baud_next  = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    w_serial_next = 1'b1;
    w_active_next = 1'b0;
    w_done_next   = 1'b0;
    case (w_state_next)
      ST_START_BIT: begin
        w_serial_next = 1'b0;
        w_active_next = 1'b1;
      end
      ST_DATA_BITS: begin
        w_serial_next = w_shift_next[0];
        w_active_next = 1'b1;
      end
      ST_STOP_BIT:  w_active_next = 1'b1;
      ST_CLEANUP:   w_done_next   = 1'b1;
      default:      ;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_serial  <= w_serial_next;
      r_active  <= w_active_next;
      r_done    <= w_done_next;
    end
  end

  assign o_TX_Ready  = !w_fifo_full;
  assign o_TX_Serial = r_serial;
  assign o_TX_Active = r_active;
  assign o_TX_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. A timeline model (queue of accepted bytes plus
// a cycle offset into the current frame) predicts all four outputs every
// cycle; directed scenarios add hand-computed timing and data expectations.
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tx_dv   = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Ready (tx_ready),
    .o_TX_Serial(tx_serial),
    .o_TX_Active(tx_active),
    .o_TX_Done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  // m_phase = cycles since the start-bit edge (0..FRAME-1 on the line,
  // FRAME = cleanup cycle), or -1 when idle.
  byte unsigned m_q[$];
  int           m_phase = -1;
  logic [7:0]   m_cur   = 8'h00;
  bit           m_ready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_phase = -1;
      m_ready = 1'b1;
    end else begin
      bit accept;
      accept = tx_dv && m_ready;
      if (m_phase < 0) begin
        if (m_q.size() > 0) begin
          m_cur   = m_q.pop_front();
          m_phase = 0;
        end
      end else begin
        m_phase++;
        if (m_phase > FRAME) m_phase = -1;
      end
      if (accept) m_q.push_back(tx_byte);
      m_ready = (m_q.size() < DEPTH);
    end
  end

  function automatic logic exp_serial();
    logic [7:0] t;
    if (m_phase >= 0 && m_phase < CPB) return 1'b0;
    if (m_phase >= CPB && m_phase < 9 * CPB) begin
      t = m_cur >> ((m_phase - CPB) / CPB);
      return t[0];
    end
    return 1'b1;
  endfunction

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    check("model_serial", tx_serial, exp_serial());
    check("model_active", tx_active, (m_phase >= 0 && m_phase < FRAME));
    check("model_done",   tx_done,   (m_phase == FRAME));
    check("model_ready",  tx_ready,  m_ready);
  end

  // ---------------- event recorder ----------------
  int   start_q[$];
  int   done_q[$];
  logic prev_active = 1'b0;
  logic prev_done   = 1'b0;

  always @(negedge clk) begin
    if (tx_active && !prev_active) start_q.push_back(cyc);
    if (tx_done && !prev_done) done_q.push_back(cyc);
    prev_active = tx_active;
    prev_done   = tx_done;
  end

  // ---------------- loopback receiver (mid-bit sampler) ----------------
  bit           rx_en = 1'b0;
  byte unsigned rx_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && tx_serial === 1'b0) begin
        logic [7:0] b;
        repeat (CPB / 2 - 1) @(negedge clk);
        if (tx_serial === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_serial;
          end
          repeat (CPB) @(negedge clk);
          if (tx_serial === 1'b1) rx_q.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drives one write strobe; t is the cycle count at the driving negedge,
  // so the start bit is visible at cycle t+2 when the transmitter is idle.
  task automatic send(input logic [7:0] b, output int t);
    @(negedge clk);
    t       = cyc;
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = ~b;
  endtask

  int t0;
  int ts;
  int tmp;

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_ready",  tx_ready,  1'b1);
    check("rst_active", tx_active, 1'b0);
    check("rst_done",   tx_done,   1'b0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ---- single byte 0xA5: bits LSB first 1,0,1,0,0,1,0,1 ----
    start_q.delete();
    done_q.delete();
    send(8'hA5, t0);
    ts = t0 + 2;
    wait_until(ts - 1);
    check("a5_pre_start", tx_serial, 1'b1);
    wait_until(ts);
    check("a5_start_low", tx_serial, 1'b0);
    check("a5_active",    tx_active, 1'b1);
    wait_until(ts + CPB - 1);
    check("a5_start_end", tx_serial, 1'b0);
    wait_until(ts + 24);
    check("a5_bit0", tx_serial, 1'b1);
    wait_until(ts + 40);
    check("a5_bit1", tx_serial, 1'b0);
    wait_until(ts + 120);
    check("a5_bit6", tx_serial, 1'b0);
    wait_until(ts + 136);
    check("a5_bit7", tx_serial, 1'b1);
    wait_until(ts + 152);
    check("a5_stop", tx_serial, 1'b1);
    wait_until(ts + 159);
    check("a5_done_early", tx_done,   1'b0);
    check("a5_active_end", tx_active, 1'b1);
    wait_until(ts + 160);
    check("a5_done_pulse", tx_done,   1'b1);
    check("a5_active_off", tx_active, 1'b0);
    wait_until(ts + 161);
    check("a5_done_width", tx_done, 1'b0);
    wait_until(ts + 200);
    check("a5_done_count", done_q.size(), 1);

    // ---- burst 0x01..0x06 on consecutive edges ----
    start_q.delete();
    rx_q.delete();
    rx_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) t0 = cyc;
      if (i == 5) check("burst_ready_before_5th", tx_ready, 1'b1);
      if (i == 6) check("burst_ready_after_5th",  tx_ready, 1'b0);
      tx_dv   = 1'b1;
      tx_byte = 8'(i);
    end
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    wait_until(t0 + 5 * (FRAME + 2) + 40);
    check("burst_frames", start_q.size(), 5);
    check("burst_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      tmp = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
      check("burst_rx_byte", tmp, i + 1);
    end
    for (int i = 1; i < 5; i++) begin
      tmp = (i < start_q.size()) ? start_q[i] - start_q[i-1] : -1;
      check("burst_spacing", tmp, FRAME + 2);
    end
    check("burst_ready_idle", tx_ready, 1'b1);
    rx_en = 1'b0;

    // ---- reset mid-frame: data bit 3 of 0x3C with 0x11, 0x22 queued ----
    start_q.delete();
    send(8'h3C, t0);
    ts = t0 + 2;
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = 8'h11;
    @(negedge clk);
    tx_byte = 8'h22;
    @(negedge clk);
    tx_dv   = 1'b0;
    wait_until(ts + 56);
    check("mid_bit2", tx_serial, 1'b1);
    wait_until(ts + 72);
    check("mid_bit3_active", tx_active, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_serial", tx_serial, 1'b1);
    check("mid_rst_active", tx_active, 1'b0);
    check("mid_rst_ready",  tx_ready,  1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    start_q.delete();
    tmp = cyc;
    wait_until(tmp + 2 * (FRAME + 2));
    check("mid_no_frame", start_q.size(), 0);
    check("mid_ready",    tx_ready,  1'b1);
    check("mid_serial",   tx_serial, 1'b1);

    // ---- loopback 0x00, 0xFF, 0x55 ----
    rx_q.delete();
    rx_en = 1'b1;
    @(negedge clk);
    t0      = cyc;
    tx_dv   = 1'b1;
    tx_byte = 8'h00;
    @(negedge clk);
    tx_byte = 8'hFF;
    @(negedge clk);
    tx_byte = 8'h55;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'hAA;
    wait_until(t0 + 3 * (FRAME + 2) + 40);
    check("loop_count", rx_q.size(), 3);
    tmp = (rx_q.size() > 0) ? int'(rx_q[0]) : -1;
    check("loop_byte0", tmp, 32'h00);
    tmp = (rx_q.size() > 1) ? int'(rx_q[1]) : -1;
    check("loop_byte1", tmp, 32'hFF);
    tmp = (rx_q.size() > 2) ? int'(rx_q[2]) : -1;
    check("loop_byte2", tmp, 32'h55);
    rx_en = 1'b0;

    // ---- write 0x7E while 0x81 is in its stop bit ----
    start_q.delete();
    done_q.delete();
    send(8'h81, t0);
    ts = t0 + 2;
    wait_until(ts + 150);
    check("wdt_in_stop", tx_active, 1'b1);
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = 8'h7E;
    @(negedge clk);
    tx_dv   = 1'b0;
    wait_until(ts + 2 * (FRAME + 2) + 20);
    check("wdt_frames", start_q.size(), 2);
    tmp = (done_q.size() > 0) ? done_q[0] : -1;
    check("wdt_done_time", tmp, ts + FRAME);
    tmp = (done_q.size() > 0 && start_q.size() > 1) ? start_q[1] - done_q[0] : -1;
    check("wdt_restart_gap", tmp, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
